// File: rtl/tlrot_host_bridge.sv
`default_nettype none
// tlrot_host_bridge: turns a req/gnt register-access port into TL-UL A-channel requests
// and returns D-channel responses, in arrival order, as a one-cycle rvalid strobe.
module tlrot_host_bridge #(
    parameter int MaxOutstanding = 2,
    parameter int SourceBase     = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        spurious_o,
    output logic        busy_o,
    output logic        a_valid,
    input  logic        a_ready,
    output logic [2:0]  a_bits_opcode,
    output logic [2:0]  a_bits_param,
    output logic [1:0]  a_bits_size,
    output logic [7:0]  a_bits_source,
    output logic [31:0] a_bits_address,
    output logic [3:0]  a_bits_mask,
    output logic [31:0] a_bits_data,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [2:0]  d_bits_opcode,
    input  logic [2:0]  d_bits_param,
    input  logic [1:0]  d_bits_size,
    input  logic [7:0]  d_bits_source,
    input  logic        d_bits_sink,
    input  logic [31:0] d_bits_data,
    input  logic        d_bits_denied
);
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    logic [MaxOutstanding-1:0] pending;
    logic [MaxOutstanding-1:0] pending_nxt;
    logic [MaxOutstanding-1:0] expect_data;
    logic [MaxOutstanding-1:0] alloc_vec;
    logic [MaxOutstanding-1:0] hit_vec;
    logic                      has_free;
    logic                      slot_free;
    logic                      d_hit;
    logic                      hit_get;
    logic                      resp_err;
    logic                      a_valid_nxt;
    logic [7:0]                alloc_src;
    logic                      unused_inputs;

    assign unused_inputs = ^{d_bits_param, d_bits_size, d_bits_sink, addr_i[1:0]};
    assign d_ready       = 1'b1;

    // Allocation looks only at the registered bitmap, so a tag freed by a D
    // response this cycle is not reusable until the next one.
    always_comb begin
        alloc_vec = '0;
        alloc_src = 8'(SourceBase);
        has_free  = 1'b0;
        for (int i = 0; i < MaxOutstanding; i++) begin
            if (!pending[i] && !has_free) begin
                has_free     = 1'b1;
                alloc_vec[i] = 1'b1;
                alloc_src    = 8'(SourceBase + i);
            end
        end
    end

    assign slot_free = !a_valid || a_ready;
    assign gnt_o     = rst_ni && req_i && slot_free && has_free;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < MaxOutstanding; i++) begin
            hit_vec[i] = d_valid && pending[i] && (d_bits_source == 8'(SourceBase + i));
        end
    end

    assign d_hit       = |hit_vec;
    assign hit_get     = |(hit_vec & expect_data);
    assign resp_err    = d_bits_denied |
                         (hit_get ? (d_bits_opcode != OP_ACK_DATA) : (d_bits_opcode != OP_ACK));
    assign pending_nxt = (pending & ~hit_vec) | (gnt_o ? alloc_vec : '0);
    assign a_valid_nxt = gnt_o || (a_valid && !a_ready);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending        <= '0;
            expect_data    <= '0;
            a_valid        <= 1'b0;
            a_bits_opcode  <= '0;
            a_bits_param   <= '0;
            a_bits_size    <= '0;
            a_bits_source  <= '0;
            a_bits_address <= '0;
            a_bits_mask    <= '0;
            a_bits_data    <= '0;
            rvalid_o       <= 1'b0;
            rdata_o        <= '0;
            err_o          <= 1'b0;
            spurious_o     <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            pending <= pending_nxt;
            a_valid <= a_valid_nxt;
            busy_o  <= (|pending_nxt) || a_valid_nxt;
            if (gnt_o) begin
                expect_data    <= (expect_data & ~alloc_vec) | (we_i ? '0 : alloc_vec);
                a_bits_opcode  <= !we_i ? OP_GET : ((be_i == 4'hf) ? OP_PUT_FULL : OP_PUT_PARTIAL);
                a_bits_param   <= 3'd0;
                a_bits_size    <= 2'd2;
                a_bits_source  <= alloc_src;
                a_bits_address <= {addr_i[31:2], 2'b00};
                a_bits_mask    <= we_i ? be_i : 4'hf;
                a_bits_data    <= we_i ? wdata_i : '0;
            end
            // Unknown or stale sources still produce an error strobe so the requester never stalls.
            rvalid_o   <= d_valid;
            err_o      <= d_valid && (!d_hit || resp_err);
            rdata_o    <= (d_hit && (d_bits_opcode == OP_ACK_DATA)) ? d_bits_data : '0;
            spurious_o <= spurious_o || (d_valid && !d_hit);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_tlrot_host_bridge.sv
`default_nettype none
// Bench for tlrot_host_bridge: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tlrot_host_bridge;
    localparam int         MAXO = 2;
    localparam int         SB   = 0;
    localparam logic [7:0] SB8  = 8'(SB);

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req_i, gnt_o, we_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  be_i;
    logic        rvalid_o, err_o, spurious_o, busy_o;
    logic [31:0] rdata_o;
    logic        a_valid, a_ready;
    logic [2:0]  a_bits_opcode, a_bits_param;
    logic [1:0]  a_bits_size;
    logic [7:0]  a_bits_source;
    logic [31:0] a_bits_address, a_bits_data;
    logic [3:0]  a_bits_mask;
    logic        d_valid, d_ready;
    logic [2:0]  d_bits_opcode, d_bits_param;
    logic [1:0]  d_bits_size;
    logic [7:0]  d_bits_source;
    logic        d_bits_sink, d_bits_denied;
    logic [31:0] d_bits_data;

    always #5 clk = ~clk;

    tlrot_host_bridge #(.MaxOutstanding(MAXO), .SourceBase(SB)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .spurious_o(spurious_o), .busy_o(busy_o),
        .a_valid(a_valid), .a_ready(a_ready), .a_bits_opcode(a_bits_opcode),
        .a_bits_param(a_bits_param), .a_bits_size(a_bits_size), .a_bits_source(a_bits_source),
        .a_bits_address(a_bits_address), .a_bits_mask(a_bits_mask), .a_bits_data(a_bits_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_bits_opcode(d_bits_opcode),
        .d_bits_param(d_bits_param), .d_bits_size(d_bits_size), .d_bits_source(d_bits_source),
        .d_bits_sink(d_bits_sink), .d_bits_data(d_bits_data), .d_bits_denied(d_bits_denied)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [7:0]  src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } abeat_t;

    typedef struct packed {
        logic [7:0] src;
        logic       get;
    } inflight_t;

    int          checks = 0;
    int          errors = 0;
    bit          m_used [MAXO];
    bit          m_get  [MAXO];
    logic        m_avalid, m_rvalid, m_err, m_spur, m_busy;
    logic [31:0] m_rdata;
    abeat_t      m_a;
    inflight_t   dev_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_free();
        for (int t = 0; t < MAXO; t++) if (!m_used[t]) return t;
        return -1;
    endfunction

    function automatic logic exp_gnt();
        return req_i && (!m_avalid || a_ready) && (first_free() >= 0);
    endfunction

    task automatic model_reset();
        for (int t = 0; t < MAXO; t++) begin
            m_used[t] = 1'b0;
            m_get[t]  = 1'b0;
        end
        m_avalid = 1'b0; m_rvalid = 1'b0; m_err = 1'b0; m_spur = 1'b0; m_busy = 1'b0;
        m_rdata  = '0;   m_a = '0;
    endtask

    task automatic compare();
        chk("gnt", {31'd0, gnt_o}, {31'd0, exp_gnt()});
        chk("d_ready", {31'd0, d_ready}, 32'd1);
        chk("a_valid", {31'd0, a_valid}, {31'd0, m_avalid});
        if (m_avalid) begin
            chk("a_opcode", {29'd0, a_bits_opcode}, {29'd0, m_a.op});
            chk("a_param", {29'd0, a_bits_param}, 32'd0);
            chk("a_size", {30'd0, a_bits_size}, 32'd2);
            chk("a_source", {24'd0, a_bits_source}, {24'd0, m_a.src});
            chk("a_address", a_bits_address, m_a.addr);
            chk("a_mask", {28'd0, a_bits_mask}, {28'd0, m_a.mask});
            chk("a_data", a_bits_data, m_a.data);
        end
        chk("rvalid", {31'd0, rvalid_o}, {31'd0, m_rvalid});
        if (m_rvalid) begin
            chk("rdata", rdata_o, m_rdata);
            chk("err", {31'd0, err_o}, {31'd0, m_err});
        end
        chk("spurious", {31'd0, spurious_o}, {31'd0, m_spur});
        chk("busy", {31'd0, busy_o}, {31'd0, m_busy});
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        int         ft;
        bit         g, hit, want_data;
        logic [7:0] diff;
        ft        = first_free();
        g         = exp_gnt();
        diff      = d_bits_source - SB8;
        hit       = d_valid && (int'(diff) < MAXO) && m_used[int'(diff) % MAXO];
        want_data = hit && m_get[int'(diff) % MAXO];
        if (hit) m_used[int'(diff)] = 1'b0;
        m_rvalid = d_valid;
        m_err    = 1'b0;
        m_rdata  = '0;
        if (d_valid) begin
            m_err = !hit || d_bits_denied || (d_bits_opcode != (want_data ? 3'd1 : 3'd0));
            if (hit && d_bits_opcode == 3'd1) m_rdata = d_bits_data;
            if (!hit) m_spur = 1'b1;
        end
        if (a_ready) m_avalid = 1'b0;
        if (g) begin
            m_used[ft] = 1'b1;
            m_get[ft]  = !we_i;
            m_avalid   = 1'b1;
            m_a.op     = !we_i ? 3'd4 : (be_i == 4'hf ? 3'd0 : 3'd1);
            m_a.src    = 8'(SB + ft);
            m_a.addr   = {addr_i[31:2], 2'b00};
            m_a.mask   = we_i ? be_i : 4'hf;
            m_a.data   = we_i ? wdata_i : 32'd0;
        end
        m_busy = m_avalid;
        for (int t = 0; t < MAXO; t++) if (m_used[t]) m_busy = 1'b1;
    endtask

    task automatic cycle();
        inflight_t e;
        @(negedge clk);
        compare();
        if (a_valid && a_ready) begin
            e.src = a_bits_source;
            e.get = (a_bits_opcode == 3'd4);
            dev_q.push_back(e);
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_i = 1'b0; d_valid = 1'b0; a_ready = 1'b0;
        rst_ni = 1'b0;
        model_reset();
        #1;
        chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_spurious", {31'd0, spurious_o}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_gnt", {31'd0, gnt_o}, 32'd0);
        chk("rst_d_ready", {31'd0, d_ready}, 32'd1);
        chk("rst_a_opcode", {29'd0, a_bits_opcode}, 32'd0);
        chk("rst_a_source", {24'd0, a_bits_source}, 32'd0);
        chk("rst_a_address", a_bits_address, 32'd0);
        chk("rst_a_mask", {28'd0, a_bits_mask}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic set_d(input logic [7:0] src, input logic [2:0] op,
                         input logic [31:0] data, input logic den);
        d_valid = 1'b1; d_bits_source = src; d_bits_opcode = op;
        d_bits_data = data; d_bits_denied = den;
    endtask

    task automatic drive_random();
        int        k;
        inflight_t e;
        req_i   = ($urandom_range(0, 9) < 6);
        we_i    = 1'($urandom_range(0, 1));
        addr_i  = $urandom;
        wdata_i = $urandom;
        case ($urandom_range(0, 3))
            0:       be_i = 4'hf;
            1:       be_i = 4'h0;
            default: be_i = 4'($urandom);
        endcase
        a_ready       = ($urandom_range(0, 9) < 7);
        d_valid       = 1'b0;
        d_bits_opcode = 3'($urandom);
        d_bits_param  = 3'($urandom);
        d_bits_size   = 2'($urandom);
        d_bits_sink   = 1'($urandom);
        d_bits_source = 8'($urandom);
        d_bits_data   = $urandom;
        d_bits_denied = ($urandom_range(0, 9) == 0);
        if (dev_q.size() > 0 && $urandom_range(0, 9) < 4) begin
            k = $urandom_range(0, dev_q.size() - 1);
            e = dev_q[k];
            dev_q.delete(k);
            d_valid       = 1'b1;
            d_bits_source = e.src;
            d_bits_opcode = e.get ? 3'd1 : 3'd0;
            if ($urandom_range(0, 9) == 0) d_bits_opcode = e.get ? 3'd0 : 3'd1;
        end else if ($urandom_range(0, 49) == 0) begin
            d_valid       = 1'b1;
            d_bits_source = 8'(SB + MAXO + $urandom_range(0, 5));
            d_bits_opcode = 3'($urandom_range(0, 1));
        end
    endtask

    initial begin
        req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; be_i = '0; a_ready = 0;
        d_valid = 0; d_bits_opcode = '0; d_bits_param = '0; d_bits_size = '0;
        d_bits_source = '0; d_bits_sink = 0; d_bits_data = '0; d_bits_denied = 0;
        #1;
        do_reset();

        // Read with AccessAckData
        req_i = 1; we_i = 0; addr_i = 32'h1000_0006; a_ready = 0;
        cycle();
        chk("rd_a_valid", {31'd0, a_valid}, 32'd1);
        chk("rd_opcode", {29'd0, a_bits_opcode}, 32'd4);
        chk("rd_address", a_bits_address, 32'h1000_0004);
        chk("rd_mask", {28'd0, a_bits_mask}, 32'hf);
        chk("rd_source", {24'd0, a_bits_source}, 32'd0);
        req_i = 0; a_ready = 1;
        cycle();
        set_d(8'd0, 3'd1, 32'hDEAD_BEEF, 1'b0);
        cycle();
        d_valid = 0;
        chk("rd_rvalid", {31'd0, rvalid_o}, 32'd1);
        chk("rd_rdata", rdata_o, 32'hDEAD_BEEF);
        chk("rd_err", {31'd0, err_o}, 32'd0);

        // Full then partial write, back-to-back
        req_i = 1; we_i = 1; be_i = 4'hf; wdata_i = 32'h1234_5678; addr_i = 32'h20;
        cycle();
        chk("wf_opcode", {29'd0, a_bits_opcode}, 32'd0);
        chk("wf_source", {24'd0, a_bits_source}, 32'd0);
        chk("wf_data", a_bits_data, 32'h1234_5678);
        be_i = 4'h3; wdata_i = 32'hAABB_CCDD; addr_i = 32'h24;
        cycle();
        chk("wp_a_valid", {31'd0, a_valid}, 32'd1);
        chk("wp_opcode", {29'd0, a_bits_opcode}, 32'd1);
        chk("wp_mask", {28'd0, a_bits_mask}, 32'h3);
        chk("wp_source", {24'd0, a_bits_source}, 32'd1);
        req_i = 0;
        cycle();
        set_d(8'd0, 3'd0, 32'h0, 1'b0);
        cycle();
        set_d(8'd1, 3'd0, 32'h0, 1'b0);
        cycle();
        d_valid = 0;

        // A-channel backpressure
        req_i = 1; we_i = 0; addr_i = 32'h30; a_ready = 0;
        cycle();
        addr_i = 32'h40;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_address", a_bits_address, 32'h30);
            chk("stall_source", {24'd0, a_bits_source}, 32'd0);
            chk("stall_gnt", {31'd0, gnt_o}, 32'd0);
        end
        a_ready = 1;
        #1;
        chk("stall_release_gnt", {31'd0, gnt_o}, 32'd1);
        cycle();
        chk("stall2_address", a_bits_address, 32'h40);
        chk("stall2_source", {24'd0, a_bits_source}, 32'd1);
        req_i = 0;
        cycle();

        // Outstanding limit, out-of-order completion
        req_i = 1; addr_i = 32'h50;
        #1;
        chk("full_gnt", {31'd0, gnt_o}, 32'd0);
        cycle();
        chk("full_gnt2", {31'd0, gnt_o}, 32'd0);
        set_d(8'd1, 3'd1, 32'h1111_2222, 1'b0);
        #1;
        chk("free_same_cycle_gnt", {31'd0, gnt_o}, 32'd0);
        cycle();
        d_valid = 0;
        #1;
        chk("free_next_gnt", {31'd0, gnt_o}, 32'd1);
        chk("ooo_rdata", rdata_o, 32'h1111_2222);
        cycle();
        chk("reuse_source", {24'd0, a_bits_source}, 32'd1);
        chk("reuse_address", a_bits_address, 32'h50);
        req_i = 0;
        cycle();
        set_d(8'd0, 3'd1, 32'hCAFE_0000, 1'b1);
        cycle();
        chk("denied_rvalid", {31'd0, rvalid_o}, 32'd1);
        chk("denied_err", {31'd0, err_o}, 32'd1);
        set_d(8'd1, 3'd1, 32'h3333_4444, 1'b0);
        cycle();
        d_valid = 0;
        cycle();
        chk("idle_busy", {31'd0, busy_o}, 32'd0);

        // Spurious response
        set_d(8'd7, 3'd0, 32'h5555_5555, 1'b0);
        cycle();
        d_valid = 0;
        chk("spur_rvalid", {31'd0, rvalid_o}, 32'd1);
        chk("spur_err", {31'd0, err_o}, 32'd1);
        chk("spur_rdata", rdata_o, 32'd0);
        chk("spur_flag", {31'd0, spurious_o}, 32'd1);
        repeat (4) cycle();
        chk("spur_sticky", {31'd0, spurious_o}, 32'd1);
        do_reset();

        // Randomized traffic with a reset in the middle
        dev_q.delete();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            drive_random();
            cycle();
        end
        req_i = 0; d_valid = 0;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tlrot_host_bridge.md
Name: tlrot_host_bridge

Overview:
- TL-UL host (initiator) bridge that turns a simple req/gnt register-access interface into TileLink-UL A-channel requests and collects D-channel responses.
- Software and test agents use it to drive the RoT device port: it issues Get/PutFullData/PutPartialData and returns read data and error status.
- It tracks up to MaxOutstanding in-flight transactions by source ID.

Parameters:
- MaxOutstanding, 2, max in-flight transactions; legal range 1..8.
- SourceBase, 0, 8-bit base source ID; transaction IDs are SourceBase..SourceBase+MaxOutstanding-1.

Ports:
- clk_i in 1: clock.
- rst_ni in 1: asynchronous active-low reset.
- req_i in 1: access request.
- gnt_o out 1: request accepted this cycle.
- we_i in 1: 1 = write, 0 = read.
- addr_i in 32: byte address.
- wdata_i in 32: write data.
- be_i in 4: byte enables.
- rvalid_o out 1: one-cycle response strobe.
- rdata_o out 32: read data, valid with rvalid_o.
- err_o out 1: response error, valid with rvalid_o.
- spurious_o out 1: sticky flag for an unexpected D response; cleared only by reset.
- busy_o out 1: any transaction pending or A slot occupied.
- a_valid out 1; a_ready in 1; a_bits_opcode out 3; a_bits_param out 3; a_bits_size out 2; a_bits_source out 8; a_bits_address out 32; a_bits_mask out 4; a_bits_data out 32.
- d_valid in 1; d_ready out 1; d_bits_opcode in 3; d_bits_param in 3; d_bits_size in 2; d_bits_source in 8; d_bits_sink in 1; d_bits_data in 32; d_bits_denied in 1.

Behaviour:
- Reset values:
  - 0: gnt_o, rvalid_o, rdata_o, err_o, spurious_o, busy_o, a_valid, all a_bits_*.
  - d_ready = 1.
  - Pending bitmap = 0, tag pointer = 0.
- A slot: a single output register.
  - "Slot free" means a_valid==0, or a_valid&&a_ready in the current cycle.
  - gnt_o = req_i && slot free && a free tag exists. Combinational; no req->gnt latency.
- Grant action, with a_valid asserted the next cycle:
  - Read: opcode 4 (Get), mask 4'hf, data 0.
  - Write with be_i==4'hf: opcode 0 (PutFullData).
  - Other writes: opcode 1 (PutPartialData), mask = be_i. be_i==0 is passed through.
  - All requests: param 0, size 2, address = {addr_i[31:2],2'b00}, source = SourceBase + allocated tag.
- A-channel hold:
  - While a_valid && !a_ready, all a_bits_* stay stable.
  - a_valid falls after the handshake unless a new grant occurs in the same cycle (back-to-back, no bubble).
- Tag allocation:
  - Lowest-index clear bit of the pending bitmap.
  - The bit is set on grant; no free bit means gnt_o=0.
- D channel: d_ready is always 1. On d_valid:
  - Let idx = d_bits_source - SourceBase. If idx is in range and pending[idx]=1:
    - Clear pending[idx].
    - Next cycle: rvalid_o=1, err_o = d_bits_denied | (opcode mismatch: Get expects 1, Put expects 0).
    - rdata_o = d_bits_data for AccessAckData, else 0.
    - Opcode type per tag is stored at grant.
  - Otherwise the response is spurious: next cycle rvalid_o=1, err_o=1, rdata_o=0, spurious_o set. Bitmap unchanged.
- Response latency and ordering:
  - Latency is 1 cycle from D handshake to rvalid_o.
  - Responses are returned in D arrival order, not issue order.
- Simultaneous events:
  - A grant and a D completion in the same cycle both apply.
  - A freed tag becomes allocatable in the following cycle, not the same cycle.
- busy_o = |pending || a_valid, registered.
- Reset mid-operation: a_valid drops immediately and the bitmap clears. Any later D response for an old source is treated as spurious.
- Ignored inputs: d_bits_param, d_bits_size and d_bits_sink are ignored.

Test Plan:
- Read at 0x1000_0006, device returns AccessAckData 0xDEADBEEF:
  - A carries opcode 4, address 0x1000_0004, mask f, source 0.
  - rvalid_o=1, rdata_o=0xDEADBEEF and err_o=0 one cycle after D.
- Write be_i=4'hf, data 0x12345678, then write be_i=4'h3:
  - opcode 0 then opcode 1, mask 3, sources 0 and 1.
  - Issued back-to-back with no bubble when a_ready=1.
- a_ready held low 5 cycles:
  - a_bits_* stable throughout.
  - gnt_o=0 for a second request until the handshake cycle.
- MaxOutstanding=2, three reads, D withheld:
  - Third request gets no gnt_o.
  - First D (source 1 returned first) lets the third issue on source 1.
- D with d_bits_denied=1 on a pending read: rvalid_o=1, err_o=1, and the tag is freed.
- D with source 7 while nothing is pending: rvalid_o=1, err_o=1, spurious_o=1 and stays 1 until rst_ni asserts.
